sr_mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous data RAM between the CPU data port (m0) and a debug/program-loader port (m1). Each port issues byte-addressed byte/half/word loads and stores. The arbiter applies round-robin arbitration, generates byte enables and lane-replicated write data, and returns aligned, sign- or zero-extended load data one cycle after the grant. It sits between the core's data-memory interface and the RAM macro.

---
 rtl/sr_mem_arbiter_pkg.sv | 24 ++
 rtl/sr_mem_arbiter_if.sv | 26 ++
 rtl/sr_mem_lane.sv | 48 ++++
 rtl/sr_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_sr_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_mem_arbiter_pkg.sv
// Shared definitions for the two-port data-RAM arbiter: access size codes,
// arbiter state encoding and the context kept for the response cycle.
package sr_mem_arbiter_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arbState_t;

  // Everything the response cycle needs to know about the granted access
  typedef struct packed {
    logic       port;
    logic [1:0] addrLow;
    logic [1:0] size;
    logic       sign;
    logic       err;
  } respInfo_t;

endpackage

// File: rtl/sr_mem_arbiter_if.sv
// One requester's byte-addressed load/store port. The requester drives the
// master side; the arbiter consumes the slave side.
interface sr_mem_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, size, sign, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, size, sign, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/sr_mem_lane.sv
// Byte-lane steering for a 32-bit little-endian RAM word. Store side turns
// size/offset/data into byte enables and lane-replicated write data; load
// side pulls the addressed bytes down to bit 0 and sign/zero-extends them.
module sr_mem_lane
  import sr_mem_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLow,
  input  logic        sign,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  be,
  output logic [31:0] storeRepl,
  output logic [31:0] loadData
);

  logic [15:0] shifted;

  // Byte enables and replicated write data so every enabled lane sees the value
  always_comb begin
    be        = 4'b0000;
    storeRepl = storeData;
    case (size)
      MEM_SIZE_BYTE: begin
        be        = 4'b0001 << addrLow;
        storeRepl = {4{storeData[7:0]}};
      end
      MEM_SIZE_HALF: begin
        be        = addrLow[1] ? 4'b1100 : 4'b0011;
        storeRepl = {2{storeData[15:0]}};
      end
      MEM_SIZE_WORD: be = 4'b1111;
      default:       be = 4'b0000;
    endcase
  end

  // Align the addressed bytes to bit 0 and extend; words pass through untouched
  always_comb begin
    shifted  = 16'(loadWord >> {addrLow, 3'b000});
    loadData = loadWord;
    case (size)
      MEM_SIZE_BYTE: loadData = {{24{sign & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: loadData = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:       loadData = loadWord;
    endcase
  end

endmodule

// File: rtl/sr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// CPU data port (m0) and the debug/loader port (m1). Stores complete in the
// grant cycle; loads and erroring accesses answer one cycle later, during
// which no new grant is issued.
module sr_mem_arbiter
  import sr_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  sr_mem_arbiter_if.slave    m0,
  sr_mem_arbiter_if.slave    m1,
  output logic               ram_en,
  output logic               ram_we,
  output logic [3:0]         ram_be,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  arbState_t   state;
  logic        last;
  respInfo_t   resp;

  logic        gnt0;
  logic        gnt1;
  logic        anyGnt;
  logic        selWe;
  logic [31:0] selAddr;
  logic [1:0]  selSize;
  logic        selSign;
  logic [31:0] selWdata;
  logic        selErr;

  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [31:0] loadExt;
  logic        respActive;
  logic        rvalid0;
  logic        rvalid1;

  logic [31:ADDR_W+2] unusedAddrHi;
  logic [31:0]        unusedStoreLoad;
  logic [3:0]         unusedLoadBe;
  logic [31:0]        unusedLoadRepl;

  // Grant only from IDLE; on a tie the port that was not granted last wins
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (state == ARB_IDLE && !rst) begin
      gnt0 = m0.req && (!m1.req || last);
      gnt1 = m1.req && (!m0.req || !last);
    end
    anyGnt = gnt0 | gnt1;
  end

  // Route the granted port's request fields onto the shared path
  always_comb begin
    selWe    = m0.we;
    selAddr  = m0.addr;
    selSize  = m0.size;
    selSign  = m0.sign;
    selWdata = m0.wdata;
    if (gnt1) begin
      selWe    = m1.we;
      selAddr  = m1.addr;
      selSize  = m1.size;
      selSign  = m1.sign;
      selWdata = m1.wdata;
    end
  end

  // Misaligned halves/words and the reserved size are answered with an error
  always_comb begin
    case (selSize)
      MEM_SIZE_BYTE: selErr = 1'b0;
      MEM_SIZE_HALF: selErr = selAddr[0];
      MEM_SIZE_WORD: selErr = |selAddr[1:0];
      default:       selErr = 1'b1;
    endcase
  end

  assign unusedAddrHi = selAddr[31:ADDR_W+2];

  sr_mem_lane storeLane (
    .size      (selSize),
    .addrLow   (selAddr[1:0]),
    .sign      (1'b0),
    .storeData (selWdata),
    .loadWord  (32'd0),
    .be        (laneBe),
    .storeRepl (laneWdata),
    .loadData  (unusedStoreLoad)
  );

  // Drive the RAM in the grant cycle; erroring accesses never touch it
  always_comb begin
    ram_en    = anyGnt && !selErr;
    ram_we    = ram_en && selWe;
    ram_be    = ram_en ? laneBe : 4'b0000;
    ram_addr  = selAddr[ADDR_W+1:2];
    ram_wdata = laneWdata;
  end

  // Sequencing, round-robin pointer and the latched context of the granted access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
      resp  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (anyGnt) begin
            last         <= gnt1;
            resp.port    <= gnt1;
            resp.addrLow <= selAddr[1:0];
            resp.size    <= selSize;
            resp.sign    <= selSign;
            resp.err     <= selErr;
            if (!selWe || selErr) state <= ARB_RESP;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
      endcase
    end
  end

  sr_mem_lane loadLane (
    .size      (resp.size),
    .addrLow   (resp.addrLow),
    .sign      (resp.sign),
    .storeData (32'd0),
    .loadWord  (ram_rdata),
    .be        (unusedLoadBe),
    .storeRepl (unusedLoadRepl),
    .loadData  (loadExt)
  );

  // Response cycle: pulse rvalid on the owning port, data only for good loads
  always_comb begin
    respActive = (state == ARB_RESP);
    rvalid0    = respActive && !resp.port;
    rvalid1    = respActive &&  resp.port;
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.err    = rvalid0 && resp.err;
  assign m1.err    = rvalid1 && resp.err;
  assign m0.rdata  = (rvalid0 && !resp.err) ? loadExt : 32'd0;
  assign m1.rdata  = (rvalid1 && !resp.err) ? loadExt : 32'd0;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Self-checking bench for sr_mem_arbiter: reset values, a table of directed
// single-port accesses, hand-written arbitration/ordering/reset sequences and
// randomized accesses checked against a byte-array memory model.
module tb_sr_mem_arbiter;
  import sr_mem_arbiter_pkg::*;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  logic memClear;

  logic              ramEn;
  logic              ramWe;
  logic [3:0]        ramBe;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0]       ramWdata;
  logic [31:0]       ramRdata;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] ramArray [0:1023];
  logic [7:0]  refMem   [0:4095];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] wdata;
    bit          expErr;
    logic [3:0]  expBe;
    logic [31:0] expWrep;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [16];

  sr_mem_arbiter_if m0If ();
  sr_mem_arbiter_if m1If ();

  sr_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0If),
    .m1        (m1If),
    .ram_en    (ramEn),
    .ram_we    (ramWe),
    .ram_be    (ramBe),
    .ram_addr  (ramAddr),
    .ram_wdata (ramWdata),
    .ram_rdata (ramRdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single-port synchronous RAM with per-byte write enables
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) ramArray[i] <= 32'd0;
      ramRdata <= 32'd0;
    end else if (ramEn) begin
      if (ramWe) begin
        for (int b = 0; b < 4; b++)
          if (ramBe[b]) ramArray[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
      end else begin
        ramRdata <= ramArray[ramAddr];
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic got, input logic exp);
    checkOutput(name, {31'd0, got}, {31'd0, exp});
  endtask

  function automatic logic getGnt(input bit port);
    return port ? m1If.gnt : m0If.gnt;
  endfunction

  function automatic logic getRvalid(input bit port);
    return port ? m1If.rvalid : m0If.rvalid;
  endfunction

  function automatic logic getErr(input bit port);
    return port ? m1If.err : m0If.err;
  endfunction

  function automatic logic [31:0] getRdata(input bit port);
    return port ? m1If.rdata : m0If.rdata;
  endfunction

  task automatic drivePort(input bit port, input bit req, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input bit sign, input logic [31:0] wdata);
    if (port) begin
      m1If.req = req; m1If.we = we; m1If.addr = addr;
      m1If.size = size; m1If.sign = sign; m1If.wdata = wdata;
    end else begin
      m0If.req = req; m0If.we = we; m0If.addr = addr;
      m0If.size = size; m0If.sign = sign; m0If.wdata = wdata;
    end
  endtask

  task automatic driveIdle();
    drivePort(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    drivePort(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
  endtask

  // Present a single request on one port at the next falling edge
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [1:0] size, input bit sign, input logic [31:0] wdata);
    @(negedge clk);
    drivePort(!port, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    drivePort(port, 1'b1, we, addr, size, sign, wdata);
  endtask

  // Behavioural memory: byte array, little endian, 4 KiB aliasing window
  task automatic modelAccess(input bit we, input logic [31:0] addr, input logic [1:0] size,
                             input bit sign, input logic [31:0] wdata,
                             output bit err, output logic [31:0] rdata,
                             output logic [3:0] be, output logic [31:0] wrep);
    int n;
    int base;
    logic [31:0] val;
    logic [31:0] mask;
    err  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = int'(addr[11:0]);
    be   = 4'b0000;
    val  = 32'd0;
    if (n == 1)      wrep = {24'd0, wdata[7:0]} * 32'h01010101;
    else if (n == 2) wrep = {16'd0, wdata[15:0]} * 32'h00010001;
    else             wrep = wdata;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        be[int'(addr[1:0]) + i] = 1'b1;
        val = val | (32'(refMem[base + i]) << (8 * i));
      end
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      if (sign && n < 4 && val[8*n-1]) val = val | ~mask;
      if (we)
        for (int i = 0; i < n; i++) refMem[base + i] = wdata[8*i +: 8];
    end
    rdata = err ? 32'd0 : val;
  endtask

  // One isolated access: check the grant cycle, then the following cycle
  task automatic runTxn(input string tag, input bit port, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit sign, input logic [31:0] wdata,
                        input bit expErr, input logic [3:0] expBe, input logic [31:0] expWrep,
                        input logic [31:0] expRdata);
    logic [31:0] expAddr;
    bit          expValid;
    expAddr  = (addr >> 2) & 32'h3FF;
    expValid = !we || expErr;
    applyStimulus(port, we, addr, size, sign, wdata);
    #1;
    checkFlag({tag, " gnt"}, getGnt(port), 1'b1);
    checkFlag({tag, " other gnt"}, getGnt(!port), 1'b0);
    checkFlag({tag, " ram_en"}, ramEn, !expErr);
    if (!expErr) begin
      checkFlag({tag, " ram_we"}, ramWe, we);
      checkOutput({tag, " ram_addr"}, 32'(ramAddr), expAddr);
      checkOutput({tag, " ram_be"}, 32'(ramBe), 32'(expBe));
      if (we) checkOutput({tag, " ram_wdata"}, ramWdata, expWrep);
    end
    @(negedge clk);
    driveIdle();
    #1;
    checkFlag({tag, " rvalid"}, getRvalid(port), expValid);
    checkFlag({tag, " other rvalid"}, getRvalid(!port), 1'b0);
    checkFlag({tag, " err"}, getErr(port), expErr);
    checkOutput({tag, " rdata"}, getRdata(port), (expValid && !expErr) ? expRdata : 32'd0);
  endtask

  initial begin
    bit          mErr;
    logic [31:0] mRdata;
    logic [3:0]  mBe;
    logic [31:0] mWrep;
    int          gp;
    bit          rPort;
    bit          rWe;
    logic [31:0] rAddr;
    logic [1:0]  rSize;
    bit          rSign;
    logic [31:0] rWdata;

    rst      = 1'b1;
    memClear = 1'b1;
    driveIdle();
    for (int i = 0; i < 4096; i++) refMem[i] = 8'd0;

    // Reset values, with a request pending to show reset suppresses grants
    drivePort(1'b0, 1'b1, 1'b0, 32'h0, MEM_SIZE_WORD, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkFlag("reset gnt0", m0If.gnt, 1'b0);
    checkFlag("reset gnt1", m1If.gnt, 1'b0);
    checkFlag("reset rvalid0", m0If.rvalid, 1'b0);
    checkFlag("reset rvalid1", m1If.rvalid, 1'b0);
    checkFlag("reset err0", m0If.err, 1'b0);
    checkFlag("reset err1", m1If.err, 1'b0);
    checkOutput("reset rdata0", m0If.rdata, 32'd0);
    checkOutput("reset rdata1", m1If.rdata, 32'd0);
    checkFlag("reset ram_en", ramEn, 1'b0);
    checkFlag("reset ram_we", ramWe, 1'b0);
    checkOutput("reset ram_be", 32'(ramBe), 32'd0);
    memClear = 1'b0;
    driveIdle();
    @(negedge clk);
    rst = 1'b0;

    // Directed single-port accesses: {port, we, addr, size, sign, wdata, err, be, wrep, rdata}
    vecs[0]  = '{1'b0, 1'b1, 32'h10,   MEM_SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h13,   MEM_SIZE_BYTE, 1'b1, 32'h0,        1'b0, 4'h8, 32'h0,        32'hFFFFFFDE};
    vecs[2]  = '{1'b1, 1'b1, 32'h22,   MEM_SIZE_HALF, 1'b0, 32'h00008001, 1'b0, 4'hC, 32'h80018001, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h22,   MEM_SIZE_HALF, 1'b0, 32'h0,        1'b0, 4'hC, 32'h0,        32'h00008001};
    vecs[4]  = '{1'b0, 1'b0, 32'h22,   MEM_SIZE_HALF, 1'b1, 32'h0,        1'b0, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{1'b0, 1'b1, 32'h31,   MEM_SIZE_BYTE, 1'b0, 32'h123456A5, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h31,   MEM_SIZE_BYTE, 1'b0, 32'h0,        1'b0, 4'h2, 32'h0,        32'h000000A5};
    vecs[7]  = '{1'b1, 1'b0, 32'h31,   MEM_SIZE_BYTE, 1'b1, 32'h0,        1'b0, 4'h2, 32'h0,        32'hFFFFFFA5};
    vecs[8]  = '{1'b0, 1'b0, 32'h06,   MEM_SIZE_WORD, 1'b0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h05,   MEM_SIZE_HALF, 1'b0, 32'h0000FFFF, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h10,   MEM_SIZE_RSVD, 1'b0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h10,   MEM_SIZE_WORD, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[12] = '{1'b1, 1'b0, 32'h1010, MEM_SIZE_WORD, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[13] = '{1'b0, 1'b0, 32'h12,   MEM_SIZE_HALF, 1'b1, 32'h0,        1'b0, 4'hC, 32'h0,        32'hFFFFDEAD};
    vecs[14] = '{1'b1, 1'b0, 32'h20,   MEM_SIZE_WORD, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h80010000};
    vecs[15] = '{1'b0, 1'b0, 32'h04,   MEM_SIZE_WORD, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h00000000};

    for (int i = 0; i < 16; i++) begin
      modelAccess(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sign, vecs[i].wdata,
                  mErr, mRdata, mBe, mWrep);
      runTxn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].size,
             vecs[i].sign, vecs[i].wdata, vecs[i].expErr, vecs[i].expBe, vecs[i].expWrep,
             vecs[i].expRdata);
    end

    // Both ports hold loads after reset: grants alternate m0,m1 every other cycle
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drivePort(1'b0, 1'b1, 1'b0, 32'h10, MEM_SIZE_WORD, 1'b0, 32'd0);
    drivePort(1'b1, 1'b1, 1'b0, 32'h20, MEM_SIZE_WORD, 1'b0, 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c % 2 == 0) begin
        gp = (c / 2) % 2;
        checkFlag($sformatf("arb c%0d gnt0", c), m0If.gnt, gp == 0);
        checkFlag($sformatf("arb c%0d gnt1", c), m1If.gnt, gp == 1);
        checkFlag($sformatf("arb c%0d rvalid0", c), m0If.rvalid, 1'b0);
        checkFlag($sformatf("arb c%0d rvalid1", c), m1If.rvalid, 1'b0);
      end else begin
        gp = ((c - 1) / 2) % 2;
        checkFlag($sformatf("arb c%0d gnt0", c), m0If.gnt, 1'b0);
        checkFlag($sformatf("arb c%0d gnt1", c), m1If.gnt, 1'b0);
        checkFlag($sformatf("arb c%0d rvalid0", c), m0If.rvalid, gp == 0);
        checkFlag($sformatf("arb c%0d rvalid1", c), m1If.rvalid, gp == 1);
        checkOutput($sformatf("arb c%0d rdata", c), getRdata(gp == 1),
                    (gp == 1) ? 32'h80010000 : 32'hDEADBEEF);
      end
    end

    // Back-to-back stores from both ports: one grant per cycle, alternating
    @(negedge clk);
    drivePort(1'b0, 1'b1, 1'b1, 32'h40, MEM_SIZE_WORD, 1'b0, 32'h11111111);
    drivePort(1'b1, 1'b1, 1'b1, 32'h44, MEM_SIZE_WORD, 1'b0, 32'h22222222);
    modelAccess(1'b1, 32'h40, MEM_SIZE_WORD, 1'b0, 32'h11111111, mErr, mRdata, mBe, mWrep);
    modelAccess(1'b1, 32'h44, MEM_SIZE_WORD, 1'b0, 32'h22222222, mErr, mRdata, mBe, mWrep);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      gp = c % 2;
      checkFlag($sformatf("st c%0d gnt0", c), m0If.gnt, gp == 0);
      checkFlag($sformatf("st c%0d gnt1", c), m1If.gnt, gp == 1);
      checkFlag($sformatf("st c%0d ram_we", c), ramWe, 1'b1);
      checkOutput($sformatf("st c%0d ram_addr", c), 32'(ramAddr), (gp == 1) ? 32'h11 : 32'h10);
    end

    // Store then load of the same word in consecutive cycles sees the new data
    @(negedge clk);
    driveIdle();
    drivePort(1'b0, 1'b1, 1'b1, 32'h40, MEM_SIZE_WORD, 1'b0, 32'hCAFEF00D);
    modelAccess(1'b1, 32'h40, MEM_SIZE_WORD, 1'b0, 32'hCAFEF00D, mErr, mRdata, mBe, mWrep);
    #1;
    checkFlag("raw store gnt0", m0If.gnt, 1'b1);
    @(negedge clk);
    driveIdle();
    drivePort(1'b1, 1'b1, 1'b0, 32'h40, MEM_SIZE_WORD, 1'b0, 32'd0);
    #1;
    checkFlag("raw load gnt1", m1If.gnt, 1'b1);
    checkFlag("raw load ram_we", ramWe, 1'b0);
    @(negedge clk);
    driveIdle();
    #1;
    checkFlag("raw rvalid1", m1If.rvalid, 1'b1);
    checkOutput("raw rdata1", m1If.rdata, 32'hCAFEF00D);

    // Reset during the response cycle drops the response and restores the pointer
    @(negedge clk);
    drivePort(1'b0, 1'b1, 1'b0, 32'h40, MEM_SIZE_WORD, 1'b0, 32'd0);
    #1;
    checkFlag("rstresp gnt0", m0If.gnt, 1'b1);
    @(negedge clk);
    driveIdle();
    rst = 1'b1;
    #1;
    checkFlag("rstresp rvalid0 in reset", m0If.rvalid, 1'b0);
    checkOutput("rstresp rdata0 in reset", m0If.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkFlag("rstresp rvalid0 after", m0If.rvalid, 1'b0);
    checkFlag("rstresp rvalid1 after", m1If.rvalid, 1'b0);
    @(negedge clk);
    drivePort(1'b0, 1'b1, 1'b0, 32'h40, MEM_SIZE_WORD, 1'b0, 32'd0);
    drivePort(1'b1, 1'b1, 1'b0, 32'h44, MEM_SIZE_WORD, 1'b0, 32'd0);
    #1;
    checkFlag("rstresp tie gnt0", m0If.gnt, 1'b1);
    checkFlag("rstresp tie gnt1", m1If.gnt, 1'b0);
    @(negedge clk);
    driveIdle();
    #1;
    checkFlag("rstresp tie rvalid0", m0If.rvalid, 1'b1);
    checkOutput("rstresp tie rdata0", m0If.rdata, 32'hCAFEF00D);

    // A request raised during the bubble and withdrawn before grant leaves no trace
    @(negedge clk);
    drivePort(1'b0, 1'b1, 1'b0, 32'h44, MEM_SIZE_WORD, 1'b0, 32'd0);
    #1;
    checkFlag("wd gnt0", m0If.gnt, 1'b1);
    @(negedge clk);
    driveIdle();
    drivePort(1'b1, 1'b1, 1'b0, 32'h10, MEM_SIZE_WORD, 1'b0, 32'd0);
    #1;
    checkFlag("wd bubble gnt1", m1If.gnt, 1'b0);
    checkFlag("wd rvalid0", m0If.rvalid, 1'b1);
    checkOutput("wd rdata0", m0If.rdata, 32'h22222222);
    @(negedge clk);
    driveIdle();
    #1;
    checkFlag("wd ram_en", ramEn, 1'b0);
    checkFlag("wd rvalid1", m1If.rvalid, 1'b0);
    @(negedge clk);
    #1;
    checkFlag("wd rvalid1 later", m1If.rvalid, 1'b0);

    // Randomized single-port accesses against the byte-array model
    for (int k = 0; k < 250; k++) begin
      rPort  = 1'($urandom_range(0, 1));
      rWe    = 1'($urandom_range(0, 1));
      rAddr  = $urandom & 32'hFFFF_F03F;
      rSize  = 2'($urandom_range(0, 3));
      rSign  = 1'($urandom_range(0, 1));
      rWdata = $urandom;
      modelAccess(rWe, rAddr, rSize, rSign, rWdata, mErr, mRdata, mBe, mWrep);
      runTxn($sformatf("rnd%0d", k), rPort, rWe, rAddr, rSize, rSign, rWdata,
             mErr, mBe, mWrep, mRdata);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
